imem_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the CPU31 core.
- Owns the PC, drives the combinational-read IMEM (11-bit word address, 32-bit instr), and buffers fetched words in a small FIFO.
- Presents {pc, instr} to decode over a valid/ready handshake.
- Handles branch/jump redirects (flush plus PC reload), a halt gate, and sticky fetch faults for misaligned or out-of-range PCs.

---
 rtl/cpu31_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/imem_fetch_ctrl.sv | 106 ++++++++++
 tb/tb_imem_fetch_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu31_pkg.sv
// Shared CPU31 fetch types and reset/memory-map defaults.
package cpu31_pkg;

   localparam logic [31:0] RESET_PC_DEF  = 32'h0040_0000;
   localparam logic [31:0] IMEM_BASE_DEF = 32'h0040_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs; flush empties it in one cycle.
module fetch_fifo
   import cpu31_pkg::*;
#(
   parameter int unsigned BUF_DEPTH = 2,
   localparam int unsigned PTR_W = $clog2(BUF_DEPTH),
   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push_i,
   input  logic               pop_i,
   input  logic               flush_i,
   input  fetch_entry_t       data_i,
   output fetch_entry_t       head_o,
   output logic [CNT_W-1:0]   count_o
);

   fetch_entry_t     mem_q [BUF_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Pointer/count update; depth is a power of two so pointers wrap naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
         else if (pop_i && !push_i) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// CPU31 instruction-fetch sequencer: owns the PC, reads IMEM, buffers words for decode,
// and handles redirects, halt and sticky fetch faults.
module imem_fetch_ctrl
   import cpu31_pkg::*;
#(
   parameter int unsigned ADDR_W    = 11,
   parameter logic [31:0] BASE_ADDR = IMEM_BASE_DEF,
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter int unsigned BUF_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_ena,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_instr,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   input  logic              halt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [31:0]       out_pc,
   output logic              fetch_fault
);

   localparam int unsigned CNT_W      = $clog2(BUF_DEPTH + 1);
   localparam logic [31:0] IMEM_BYTES = 32'(4 * (2 ** ADDR_W));

   fetch_state_t     state_q, state_d;
   logic [31:0]      pc_q, pc_d, pc_off;
   logic             fault_q, fault_d;
   logic             pc_legal, run_free, fault_go;
   logic             buf_push, buf_pop, buf_flush, buf_full, buf_nonempty;
   logic [CNT_W-1:0] buf_count;
   fetch_entry_t     buf_head, push_entry;

   // Unsigned offset: PCs below BASE wrap to huge values and fail the range test.
   assign pc_off       = pc_q - BASE_ADDR;
   assign pc_legal     = (pc_q[1:0] == 2'b00) && (pc_off < IMEM_BYTES);
   assign buf_nonempty = (buf_count != '0);
   assign buf_full     = (buf_count == CNT_W'(BUF_DEPTH));
   assign run_free     = (state_q == RUN) && !halt && !redirect_valid;
   assign fault_go     = run_free && !pc_legal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = RUN;
         RUN:     if (fault_go) state_d = FAULT;
         FAULT:   state_d = FAULT;
         default: state_d = IDLE;
      endcase
   end

   // Redirect outranks everything; a handshake in a redirect cycle is discarded.
   always_comb begin
      imem_ena  = 1'b0;
      buf_push  = 1'b0;
      buf_flush = 1'b0;
      pc_d      = pc_q;
      fault_d   = fault_q | fault_go;
      buf_pop   = buf_nonempty && out_ready && !redirect_valid;
      if (redirect_valid && (state_q != FAULT)) begin
         buf_flush = 1'b1;
         pc_d      = redirect_pc;
      end else if (run_free && pc_legal && (!buf_full || buf_pop)) begin
         imem_ena = 1'b1;
         buf_push = 1'b1;
         pc_d     = pc_q + 32'd4;
      end
   end

   assign push_entry = fetch_entry_t'{pc: pc_q, instr: imem_instr};

   fetch_fifo #(
      .BUF_DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (buf_push),
      .pop_i   (buf_pop),
      .flush_i (buf_flush),
      .data_i  (push_entry),
      .head_o  (buf_head),
      .count_o (buf_count)
   );

   assign imem_addr   = pc_off[ADDR_W+1:2];
   assign out_valid   = buf_nonempty && !redirect_valid;
   assign out_pc      = buf_nonempty ? buf_head.pc    : 32'd0;
   assign out_instr   = buf_nonempty ? buf_head.instr : 32'd0;
   assign fetch_fault = fault_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed timing checks plus an in-order {pc, instr} scoreboard.
module tb_imem_fetch_ctrl;
   import cpu31_pkg::*;

   localparam logic [31:0] BASE = 32'h0040_0000;

   logic        clk;
   logic        rst_n;
   logic        imem_ena;
   logic [10:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        fetch_fault;

   logic [31:0]  imem [2048];
   fetch_entry_t exp_q [$];
   int unsigned  checks   = 0;
   int unsigned  failures = 0;

   imem_fetch_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_ena       (imem_ena),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .fetch_fault    (fetch_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign imem_instr = imem[imem_addr];

   function automatic logic [31:0] imem_word(input int unsigned idx);
      return 32'hC0DE_0000 | 32'(idx);
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic push_seq(input int unsigned first, input int unsigned n);
      for (int unsigned i = first; i < first + n; i++)
         exp_q.push_back(fetch_entry_t'{pc: BASE + 32'(4 * i), instr: imem_word(i)});
   endtask

   // Called at posedge+1: reload the expected stream and release reset.
   task automatic release_reset();
      exp_q.delete();
      push_seq(0, 2048);
      rst_n = 1'b1;
   endtask

   // Every accepted head must match the next expected entry in order.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_pc", out_pc, 32'hFFFF_FFFF);
         end else begin
            fetch_entry_t e;
            e = exp_q.pop_front();
            check("sb_pc", out_pc, e.pc);
            check("sb_instr", out_instr, e.instr);
         end
      end
   end

   initial begin
      int  n;
      bit  found;
      for (int i = 0; i < 2048; i++) imem[i] = imem_word(32'(i));
      rst_n = 1'b1; out_ready = 1'b1; halt = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'd0;
      #2 rst_n = 1'b0;
      repeat (2) tick();

      mid();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_pc", out_pc, 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_imem_ena", 32'(imem_ena), 32'd0);
      check("rst_imem_addr", 32'(imem_addr), 32'd0);
      check("rst_fault", 32'(fetch_fault), 32'd0);
      tick();

      // Streaming from reset
      release_reset();
      mid(); check("idle_ena", 32'(imem_ena), 32'd0); check("idle_valid", 32'(out_valid), 32'd0); tick();
      mid(); check("first_ena", 32'(imem_ena), 32'd1); check("first_addr", 32'(imem_addr), 32'd0);
      check("first_valid_early", 32'(out_valid), 32'd0); tick();
      mid(); check("first_valid", 32'(out_valid), 32'd1); check("first_pc", out_pc, BASE);
      check("stream_addr1", 32'(imem_addr), 32'd1); tick();
      for (int i = 2; i <= 6; i++) begin
         mid(); check("stream_addr", 32'(imem_addr), 32'(i)); tick();
      end

      // Backpressure: buffer fills, fetch stops, head holds
      out_ready = 1'b0;
      mid(); check("bp_fill_ena", 32'(imem_ena), 32'd1); check("bp_fill_addr", 32'(imem_addr), 32'd7); tick();
      repeat (4) begin
         mid();
         check("bp_full_ena", 32'(imem_ena), 32'd0);
         check("bp_head_pc", out_pc, exp_q[0].pc);
         tick();
      end
      out_ready = 1'b1;
      mid(); check("bp_resume_ena", 32'(imem_ena), 32'd1); check("bp_resume_addr", 32'(imem_addr), 32'd8); tick();
      repeat (3) tick();

      // Redirect while full
      redirect_valid = 1'b1; redirect_pc = 32'h0040_0100;
      exp_q.delete(); push_seq(64, 16);
      mid(); check("redir_mask_valid", 32'(out_valid), 32'd0); check("redir_no_fetch", 32'(imem_ena), 32'd0); tick();
      redirect_valid = 1'b0;
      mid(); check("redir_addr", 32'(imem_addr), 32'h040); check("redir_ena", 32'(imem_ena), 32'd1);
      check("redir_flushed", 32'(out_valid), 32'd0); tick();
      mid(); check("redir_valid", 32'(out_valid), 32'd1); check("redir_pc", out_pc, 32'h0040_0100);
      check("redir_instr", out_instr, imem_word(64)); tick();
      repeat (2) tick();

      // Misaligned redirect target faults on its fetch attempt
      redirect_valid = 1'b1; redirect_pc = 32'h0040_0102;
      exp_q.delete();
      mid(); check("mis_mask_valid", 32'(out_valid), 32'd0); tick();
      redirect_valid = 1'b0;
      mid(); check("mis_no_fetch", 32'(imem_ena), 32'd0); check("mis_fault_pending", 32'(fetch_fault), 32'd0);
      check("mis_empty", 32'(out_valid), 32'd0); tick();
      redirect_valid = 1'b1; redirect_pc = BASE;
      mid(); check("mis_fault", 32'(fetch_fault), 32'd1); tick();
      redirect_valid = 1'b0;
      repeat (2) begin
         mid();
         check("fault_sticky", 32'(fetch_fault), 32'd1);
         check("fault_no_fetch", 32'(imem_ena), 32'd0);
         check("fault_no_valid", 32'(out_valid), 32'd0);
         tick();
      end

      // Async reset clears the fault immediately
      rst_n = 1'b0; #1;
      check("async_fault_clear", 32'(fetch_fault), 32'd0);
      tick();
      release_reset();
      repeat (2) tick();
      mid(); check("restart_pc", out_pc, BASE); tick();
      repeat (2) tick();

      // Halt mid-stream: no fetch, buffered entry still drains
      halt = 1'b1;
      mid(); check("halt_ena", 32'(imem_ena), 32'd0); check("halt_drain", 32'(out_valid), 32'd1); tick();
      mid(); check("halt_ena2", 32'(imem_ena), 32'd0); check("empty_valid", 32'(out_valid), 32'd0);
      check("empty_pc", out_pc, 32'd0); check("empty_instr", out_instr, 32'd0); tick();
      mid(); check("halt_ena3", 32'(imem_ena), 32'd0); tick();
      halt = 1'b0;
      mid(); check("halt_resume_ena", 32'(imem_ena), 32'd1); check("halt_resume_addr", 32'(imem_addr), 32'd4); tick();
      repeat (3) tick();

      // Async reset mid-stream, then run sequentially to the last IMEM word
      rst_n = 1'b0; #1;
      check("async_valid_clear", 32'(out_valid), 32'd0);
      check("async_addr_clear", 32'(imem_addr), 32'd0);
      tick();
      release_reset();
      n = 0; found = 1'b0;
      while (n < 3000) begin
         mid();
         if (imem_ena && imem_addr == 11'h7FF) begin
            found = 1'b1;
            break;
         end
         tick();
         n++;
      end
      check("last_word_fetch", 32'(found), 32'd1);
      tick();
      mid(); check("range_no_fetch", 32'(imem_ena), 32'd0); check("last_word_pc", out_pc, 32'h0040_1FFC); tick();
      mid(); check("range_fault", 32'(fetch_fault), 32'd1); check("range_drained", 32'(out_valid), 32'd0); tick();
      check("sb_all_delivered", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
